// File: rtl/alu_arb_pkg.sv
// Shared encodings for the ALU datapath arbiter: FSM states, instruction
// widths and the field offsets of {opcode, ra1, ra2, wa}.
package alu_arb_pkg;

  localparam int ARB_OP_W    = 3;
  localparam int ARB_RA_W    = 2;
  localparam int ARB_INSTR_W = ARB_OP_W + 3 * ARB_RA_W;

  localparam int ARB_WA_LSB  = 0;
  localparam int ARB_RA2_LSB = ARB_RA_W;
  localparam int ARB_RA1_LSB = 2 * ARB_RA_W;
  localparam int ARB_OP_LSB  = 3 * ARB_RA_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_WB   = 2'b10
  } arb_state_t;

endpackage

// File: rtl/alu_datapath_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index strictly after ptr,
// wrapping, returned as one-hot grant, binary index and an any-valid flag.
module rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         idx,
  output logic               any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |valid;
    // Walk farthest-to-nearest so the nearest valid index after ptr wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      int j;
      j = (int'(ptr) + k) % NUM_REQ;
      if (valid[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = 2'(j);
      end
    end
  end

endmodule

// File: rtl/alu_datapath_arbiter.sv
// Round-robin arbiter sharing one ALU/RegFile datapath between NUM_REQ sources,
// sequencing IDLE -> EXEC -> WB. Optional macro ALU_ARB_LOCK_EN adds req_lock.
module alu_datapath_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int OP_W    = ARB_OP_W,
  parameter int RA_W    = ARB_RA_W,
  parameter int INSTR_W = ARB_INSTR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*INSTR_W-1:0] req_instr,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_lock,
`endif
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [OP_W-1:0]            opcode,
  output logic [RA_W-1:0]            ra1,
  output logic [RA_W-1:0]            ra2,
  output logic [RA_W-1:0]            wa,
  output logic                       we,
  output logic                       busy,
  output logic [1:0]                 grant_id
);

  localparam int WA_LSB  = 0;
  localparam int RA2_LSB = RA_W;
  localparam int RA1_LSB = 2 * RA_W;
  localparam int OP_LSB  = 3 * RA_W;

  arb_state_t           state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, sel_instr;
  logic [1:0]           owner_q, rr_q, load_idx;
  logic                 load, adv_rr;
  logic [NUM_REQ-1:0]   ready_c;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [1:0]           pick_idx;
  logic                 pick_any;
  logic                 owner_valid;
`ifdef ALU_ARB_LOCK_EN
  logic                 owner_lock;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (rr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    owner_valid = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    owner_lock  = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == 2'(i)) begin
        owner_valid = req_valid[i];
`ifdef ALU_ARB_LOCK_EN
        owner_lock  = req_lock[i];
`endif
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ready_c  = '0;
    req_done = '0;
    load     = 1'b0;
    load_idx = owner_q;
    adv_rr   = 1'b0;
    opcode   = '0;
    ra1      = '0;
    ra2      = '0;
    wa       = '0;
    we       = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          ready_c  = pick_grant;
          load     = 1'b1;
          load_idx = pick_idx;
          adv_rr   = 1'b1;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        opcode  = instr_q[OP_LSB +: OP_W];
        ra1     = instr_q[RA1_LSB +: RA_W];
        ra2     = instr_q[RA2_LSB +: RA_W];
        wa      = instr_q[WA_LSB +: RA_W];
        busy    = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        opcode  = instr_q[OP_LSB +: OP_W];
        ra1     = instr_q[RA1_LSB +: RA_W];
        ra2     = instr_q[RA2_LSB +: RA_W];
        wa      = instr_q[WA_LSB +: RA_W];
        we      = 1'b1;
        busy    = 1'b1;
        for (int i = 0; i < NUM_REQ; i++)
          if (owner_q == 2'(i)) req_done[i] = 1'b1;
        state_d = S_IDLE;
`ifdef ALU_ARB_LOCK_EN
        // Locked owner keeps the datapath; rr pointer deliberately left alone.
        if (owner_lock && owner_valid) begin
          for (int i = 0; i < NUM_REQ; i++)
            if (owner_q == 2'(i)) ready_c[i] = 1'b1;
          load    = 1'b1;
          state_d = S_EXEC;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel_instr = instr_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (load_idx == 2'(i)) sel_instr = req_instr[i*INSTR_W +: INSTR_W];
  end

  // Ready is combinational from req_valid, so mask it while reset is held.
  assign req_ready = ready_c & ~{NUM_REQ{reset}};
  assign grant_id  = owner_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      owner_q <= '0;
      rr_q    <= 2'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      if (load) begin
        instr_q <= sel_instr;
        owner_q <= load_idx;
      end
      if (adv_rr) rr_q <= load_idx;
    end
  end

  wire unused_ok = owner_valid;

endmodule

// File: tb/tb_alu_datapath_arbiter.sv
// Directed self-checking bench for alu_datapath_arbiter (NUM_REQ=2); the
// lock sequence is exercised only when ALU_ARB_LOCK_EN is defined.
module tb_alu_datapath_arbiter;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [17:0] req_instr;
`ifdef ALU_ARB_LOCK_EN
  logic [1:0]  req_lock;
`endif
  logic [1:0]  req_ready, req_done;
  logic [2:0]  opcode;
  logic [1:0]  ra1, ra2, wa;
  logic        we, busy;
  logic [1:0]  grant_id;

  int total = 0;
  int bad   = 0;

  alu_datapath_arbiter #(.NUM_REQ(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_instr (req_instr),
`ifdef ALU_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .req_done  (req_done),
    .opcode    (opcode),
    .ra1       (ra1),
    .ra2       (ra2),
    .wa        (wa),
    .we        (we),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] a1,
                                    input logic [1:0] a2, input logic [1:0] w);
    logic [8:0] r;
    r = '0;
    r[ARB_OP_LSB  +: 3] = op;
    r[ARB_RA1_LSB +: 2] = a1;
    r[ARB_RA2_LSB +: 2] = a2;
    r[ARB_WA_LSB  +: 2] = w;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  logic [8:0] i_a, i_b, i_c, i_d;
  logic [1:0] exp_ready;

  initial begin
    i_a = 9'b001_01_10_11;
    i_b = mk(3'b110, 2'b11, 2'b00, 2'b01);
    i_c = mk(3'b010, 2'b10, 2'b01, 2'b00);
    i_d = mk(3'b101, 2'b00, 2'b11, 2'b10);
    reset     = 1'b1;
    req_valid = 2'b11;
    req_instr = {i_b, i_a};
`ifdef ALU_ARB_LOCK_EN
    req_lock  = 2'b00;
`endif
    @(negedge clk);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_fields", {opcode, ra1, ra2, wa, grant_id}, 11'd0);
    req_valid = 2'b00;
    @(posedge clk); #1 reset = 1'b0;

    // single op from req0: accept, EXEC, WB
    @(posedge clk); #1;
    req_instr = {9'h000, i_a};
    req_valid = 2'b01;
    @(negedge clk);
    chk("t2_ready", req_ready, 2'b01);
    chk("t2_idle_busy", busy, 1'b0);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    chk("t2_exec_fields", {opcode, ra1, ra2, wa}, {3'b001, 2'b01, 2'b10, 2'b11});
    chk("t2_exec_we", we, 1'b0);
    chk("t2_exec_busy", busy, 1'b1);
    chk("t2_exec_done", req_done, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_wb_we", we, 1'b1);
    chk("t2_wb_done", req_done, 2'b01);
    chk("t2_wb_wa", wa, 2'b11);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_back_idle", {busy, we, opcode}, 5'd0);

    // req1 granted, then reset asserted mid-EXEC
    @(posedge clk); #1;
    req_instr = {i_b, 9'h000};
    req_valid = 2'b10;
    @(negedge clk);
    chk("t1_ready", req_ready, 2'b10);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    chk("t1_exec_busy", busy, 1'b1);
    chk("t1_exec_gid", grant_id, 2'd1);
    #1;
    reset     = 1'b1;
    req_valid = 2'b11;
    req_instr = {i_d, i_c};
    #1;
    chk("t1_abort_ctl", {we, busy, req_ready, req_done}, 6'd0);
    chk("t1_abort_gid", grant_id, 2'd0);
    chk("t1_abort_fields", {opcode, ra1, ra2, wa}, 9'd0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;

    // both held valid: grants 0,1,0,1 every 3 cycles
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k % 3 == 0) exp_ready = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
      else            exp_ready = 2'b00;
      chk($sformatf("t3_ready_%0d", k), req_ready, exp_ready);
      if (k % 3 == 1) begin
        chk($sformatf("t3_gid_%0d", k), grant_id, ((k / 3) % 2 == 0) ? 2'd0 : 2'd1);
        chk($sformatf("t3_op_%0d", k), opcode, ((k / 3) % 2 == 0) ? i_c[8:6] : i_d[8:6]);
      end
      if (k % 3 == 2)
        chk($sformatf("t3_done_%0d", k), req_done, ((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
      if (k == 11) req_valid = 2'b00;
    end

    // req1 raises then drops valid while req0 owns the datapath
    req_instr = {i_b, i_a};
    req_valid = 2'b01;
    @(negedge clk);
    chk("t4_ready0", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b10;
    @(negedge clk);
    chk("t4_exec_ready", req_ready, 2'b00);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    chk("t4_wb_ready", req_ready, 2'b00);
    chk("t4_wb_done", req_done, 2'b01);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("t4_after_%0d", k), {req_ready, busy}, 3'b000);
    end

    // 20 idle cycles with garbage on req_instr
    req_instr = '1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t6_busy", busy, 1'b0);
    chk("t6_we", we, 1'b0);
    chk("t6_fields", {opcode, ra1, ra2, wa}, 9'd0);
    chk("t6_ready_done", {req_ready, req_done}, 4'd0);

`ifdef ALU_ARB_LOCK_EN
    // req1 locked for 3 instrs at 2-cycle spacing, req0 waits
    @(posedge clk); #1;
    req_instr = {i_b, i_a};
    req_valid = 2'b11;
    req_lock  = 2'b10;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      case (k)
        0, 2, 4: exp_ready = 2'b10;
        7:       exp_ready = 2'b01;
        default: exp_ready = 2'b00;
      endcase
      chk($sformatf("t5_ready_%0d", k), req_ready, exp_ready);
      if (k == 1 || k == 3 || k == 5)
        chk($sformatf("t5_gid_%0d", k), grant_id, 2'd1);
      @(posedge clk); #1;
      if (k == 0) req_instr = {i_c, i_a};
      if (k == 2) req_instr = {i_d, i_a};
      if (k == 4) begin
        req_valid = 2'b01;
        req_lock  = 2'b00;
      end
      if (k == 7) req_valid = 2'b00;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
